// File: rtl/femto16_cpu.sv
// femto16 16-bit core: 8 registers (r6 = SP, r7 = IP), C/Z/N flags, single
// word-addressed bus with wait states for 1-cycle registered-read memories.
module femto16_cpu #(
    parameter logic [15:0] RESET_VECTOR = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    output logic        busy,
    output logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        write
);

    typedef enum logic [2:0] {
        SELECT,
        FETCH_WAIT,
        DECODE,
        MEM_WAIT,
        COMPUTE
    } state_t;

    state_t      state;
    logic [15:0] regs [8];
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic [2:0]  dest;

    logic [3:0]  opcode;
    logic [2:0]  ra_sel;
    logic [2:0]  rb_sel;
    logic [3:0]  alu_op;
    logic [3:0]  cond;
    logic [7:0]  imm8;
    logic [15:0] ra_val;
    logic [15:0] rb_val;
    logic [15:0] ip;
    logic [15:0] sp;
    logic [15:0] br_target;

    // The instruction is consumed straight off the bus in DECODE.
    assign opcode    = data_in[15:12];
    assign ra_sel    = data_in[11:9];
    assign rb_sel    = data_in[8:6];
    assign alu_op    = data_in[3:0];
    assign cond      = data_in[11:8];
    assign imm8      = data_in[7:0];
    assign ra_val    = regs[ra_sel];
    assign rb_val    = regs[rb_sel];
    assign ip        = regs[7];
    assign sp        = regs[6];
    assign br_target = ip + {{8{imm8[7]}}, imm8};
    assign busy      = (state != SELECT);

    logic [16:0] wide;
    logic [15:0] alu_res;
    logic        alu_c;
    logic        alu_c_upd;

    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_c     = flag_c;
        alu_c_upd = 1'b0;
        case (alu_op)
            4'd0:  alu_res = '0;
            4'd1:  alu_res = rb_val;
            4'd2: begin
                wide      = {1'b0, ra_val} + {1'b0, rb_val};
                alu_res   = wide[15:0];
                alu_c     = wide[16];
                alu_c_upd = 1'b1;
            end
            4'd3: begin
                wide      = {1'b0, ra_val} - {1'b0, rb_val};
                alu_res   = wide[15:0];
                alu_c     = wide[16];
                alu_c_upd = 1'b1;
            end
            4'd4: begin
                wide      = {1'b0, ra_val} + {1'b0, rb_val} + {16'b0, flag_c};
                alu_res   = wide[15:0];
                alu_c     = wide[16];
                alu_c_upd = 1'b1;
            end
            4'd5: begin
                wide      = {1'b0, ra_val} - {1'b0, rb_val} - {16'b0, flag_c};
                alu_res   = wide[15:0];
                alu_c     = wide[16];
                alu_c_upd = 1'b1;
            end
            4'd6:  alu_res = ra_val & rb_val;
            4'd7:  alu_res = ra_val | rb_val;
            4'd8:  alu_res = ra_val ^ rb_val;
            4'd9:  alu_res = ra_val + 16'd1;
            4'd10: alu_res = ra_val - 16'd1;
            4'd11: begin
                alu_res   = {ra_val[14:0], 1'b0};
                alu_c     = ra_val[15];
                alu_c_upd = 1'b1;
            end
            4'd12: begin
                alu_res   = {1'b0, ra_val[15:1]};
                alu_c     = ra_val[0];
                alu_c_upd = 1'b1;
            end
            4'd13: begin
                alu_res   = {ra_val[14:0], flag_c};
                alu_c     = ra_val[15];
                alu_c_upd = 1'b1;
            end
            4'd14: begin
                alu_res   = {flag_c, ra_val[15:1]};
                alu_c     = ra_val[0];
                alu_c_upd = 1'b1;
            end
            default: alu_res = ~ra_val;
        endcase
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (cond)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = flag_z;
            4'd2:    br_taken = !flag_z;
            4'd3:    br_taken = flag_c;
            4'd4:    br_taken = !flag_c;
            4'd5:    br_taken = flag_n;
            4'd6:    br_taken = !flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs     <= '{'0, '0, '0, '0, '0, '0, '0, RESET_VECTOR};
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            address  <= '0;
            data_out <= '0;
            write    <= 1'b0;
            dest     <= '0;
            state    <= SELECT;
        end else begin
            case (state)
                SELECT: begin
                    write <= 1'b0;
                    if (!hold) begin
                        address <= ip;
                        regs[7] <= ip + 16'd1;
                        state   <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: state <= DECODE;
                DECODE: begin
                    state <= SELECT;
                    dest  <= ra_sel;
                    case (opcode)
                        4'h0: begin
                            regs[ra_sel] <= alu_res;
                            flag_z       <= (alu_res == 16'd0);
                            flag_n       <= alu_res[15];
                            if (alu_c_upd) flag_c <= alu_c;
                        end
                        4'h1: begin
                            regs[ra_sel] <= {8'h00, imm8};
                            flag_z       <= (imm8 == 8'd0);
                            flag_n       <= 1'b0;
                        end
                        4'h2: begin
                            address <= rb_val;
                            state   <= MEM_WAIT;
                        end
                        4'h3: begin
                            address  <= rb_val;
                            data_out <= ra_val;
                            write    <= 1'b1;
                        end
                        4'h4: begin
                            address <= ip;
                            regs[7] <= ip + 16'd1;
                            state   <= MEM_WAIT;
                        end
                        4'h5: begin
                            regs[6]  <= sp - 16'd1;
                            address  <= sp - 16'd1;
                            data_out <= ra_val;
                            write    <= 1'b1;
                        end
                        4'h6: begin
                            address <= sp;
                            regs[6] <= sp + 16'd1;
                            state   <= MEM_WAIT;
                        end
                        4'h8: if (br_taken) regs[7] <= br_target;
                        4'h9: regs[7] <= ra_val;
                        // JMP reuses the load path with IP as the destination.
                        4'hA: begin
                            address <= ip;
                            dest    <= 3'd7;
                            state   <= MEM_WAIT;
                        end
                        default: ;
                    endcase
                end
                MEM_WAIT: state <= COMPUTE;
                COMPUTE: begin
                    regs[dest] <= data_in;
                    state      <= SELECT;
                end
                default: state <= SELECT;
            endcase
        end
    end

endmodule

// File: tb/tb_femto16_cpu.sv
// Bench for femto16_cpu: models ROM/RAM/LED on the bus and scoreboards every
// bus write against the writes the test program is expected to make.
module tb_femto16_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        busy;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        write;

    femto16_cpu #(.RESET_VECTOR(16'hF000)) dut (
        .clk(clk), .reset(reset), .hold(hold), .busy(busy),
        .address(address), .data_in(data_in), .data_out(data_out), .write(write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] rom [4096];
    logic [15:0] ram [4096];
    logic [15:0] led_reg = '0;

    always @(posedge clk) begin
        if (write) begin
            if (address < 16'h1000) ram[address[11:0]] <= data_out;
            else if (address == 16'h2001) led_reg <= data_out;
        end
        if (address >= 16'hF000)      data_in <= rom[address[11:0]];
        else if (address < 16'h1000)  data_in <= ram[address[11:0]];
        else if (address == 16'h2000) data_in <= 16'h00A5;
        else                          data_in <= 16'h0000;
    end

    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t sb_q[$];
    logic prev_write = 1'b0;

    always @(negedge clk) begin
        if (write) begin
            check("write_width", {15'b0, prev_write}, 16'd0);
            if (sb_q.size() == 0) begin
                check("spurious_write_addr", address, 16'hFFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", address, e.a);
                check("wr_data", data_out, e.d);
            end
        end
        prev_write <= write;
    end

    localparam logic [3:0] ZERO = 0, MOV = 1, ADD = 2, SUB = 3, ADC = 4, SBB = 5,
                           OR_ = 7, XOR_ = 8, INC = 9, DEC = 10, ASL = 11,
                           LSR = 12, ROL = 13, ROR = 14, NOT_ = 15;

    function automatic logic [15:0] alu(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
        return {4'h0, a, b, 2'b00, op};
    endfunction
    function automatic logic [15:0] ldi(input logic [2:0] a, input logic [7:0] imm);
        return {4'h1, a, 1'b0, imm};
    endfunction
    function automatic logic [15:0] ld(input logic [2:0] a, input logic [2:0] b);
        return {4'h2, a, b, 6'b0};
    endfunction
    function automatic logic [15:0] st(input logic [2:0] a, input logic [2:0] b);
        return {4'h3, a, b, 6'b0};
    endfunction
    function automatic logic [15:0] op_r(input logic [3:0] op, input logic [2:0] a);
        return {op, a, 9'b0};
    endfunction
    function automatic logic [15:0] br(input logic [3:0] c, input logic [7:0] disp);
        return {4'h8, c, disp};
    endfunction

    localparam logic [15:0] BAD = 16'h3000;  // ST r0,[r0]: must never execute
    int unsigned pc;
    logic [15:0] idle_addr;

    task automatic emit(input logic [15:0] w);
        rom[pc] = w;
        pc++;
    endtask
    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb_q.push_back(e);
    endtask
    task automatic ldw(input logic [2:0] r, input logic [15:0] v);
        emit(op_r(4'h4, r));
        emit(v);
    endtask

    task automatic build_program();
        logic [15:0] tgt;
        pc = 0;
        emit(ldi(0, 8'hFF));
        ldw(1, 16'h0001);
        emit(alu(0, 1, ADD));                       // r0=0x0100 C=0 Z=0
        emit(br(4'd2, 8'h01)); emit(BAD);
        emit(br(4'd4, 8'h01)); emit(BAD);
        ldw(5, 16'h0010);
        emit(st(0, 5));            exp_wr(16'h0010, 16'h0100);
        emit(ld(3, 5));
        ldw(5, 16'h0011);
        emit(st(3, 5));            exp_wr(16'h0011, 16'h0100);
        ldw(5, 16'h2001);
        emit(st(0, 5));            exp_wr(16'h2001, 16'h0100);
        ldw(2, 16'h0001); ldw(4, 16'h0002);
        emit(alu(2, 4, SUB));                       // 0xFFFF C=1 N=1
        emit(br(4'd5, 8'h01)); emit(BAD);
        emit(br(4'd3, 8'h01)); emit(BAD);
        ldw(5, 16'h0020);
        emit(st(2, 5));            exp_wr(16'h0020, 16'hFFFF);
        emit(alu(2, 0, INC));                       // 0 Z=1 C stays 1
        emit(br(4'd1, 8'h01)); emit(BAD);
        emit(br(4'd3, 8'h01)); emit(BAD);
        emit(br(4'd7, 8'h01)); emit(st(2, 5)); exp_wr(16'h0020, 16'h0000);
        emit(alu(4, 0, ZERO));
        emit(alu(4, 4, ADC));                       // 1 C=0
        emit(st(4, 5));            exp_wr(16'h0020, 16'h0001);
        ldw(4, 16'h8001);
        emit(alu(4, 0, ASL));                       // 0x0002 C=1
        emit(alu(4, 0, ROR));                       // 0x8001 C=0
        emit(st(4, 5));            exp_wr(16'h0020, 16'h8001);
        emit(alu(4, 0, LSR));                       // 0x4000 C=1
        emit(alu(4, 1, SBB));                       // 0x3FFE C=0
        emit(st(4, 5));            exp_wr(16'h0020, 16'h3FFE);
        emit(alu(4, 0, XOR_));
        emit(alu(4, 0, NOT_));                      // 0xC101 N=1
        emit(br(4'd5, 8'h01)); emit(BAD);
        emit(st(4, 5));            exp_wr(16'h0020, 16'hC101);
        ldw(4, 16'hFFFF);
        emit(alu(4, 1, ADD));                       // wrap: 0 C=1 Z=1
        emit(br(4'd3, 8'h01)); emit(BAD);
        emit(br(4'd1, 8'h01)); emit(BAD);
        emit(st(4, 5));            exp_wr(16'h0020, 16'h0000);
        emit(alu(4, 0, MOV));
        emit(alu(4, 1, OR_));
        emit(alu(4, 0, ROL));                       // C=1 from ADD: 0x0203
        emit(st(4, 5));            exp_wr(16'h0020, 16'h0203);
        emit(ldi(2, 8'd3));
        emit(alu(2, 0, DEC));
        emit(st(2, 5));
        emit(br(4'd2, 8'hFD));
        exp_wr(16'h0020, 16'h0002); exp_wr(16'h0020, 16'h0001); exp_wr(16'h0020, 16'h0000);
        ldw(6, 16'h1000);
        emit(op_r(4'h5, 1));       exp_wr(16'h0FFF, 16'h0001);
        emit(op_r(4'h6, 4));
        emit(st(4, 5));            exp_wr(16'h0020, 16'h0001);
        emit(st(6, 5));            exp_wr(16'h0020, 16'h1000);
        tgt = 16'hF000 + 16'(pc) + 16'd4;
        ldw(3, tgt);
        emit(alu(7, 3, MOV)); emit(BAD);
        tgt = 16'hF000 + 16'(pc) + 16'd4;
        ldw(3, tgt);
        emit(op_r(4'h9, 3)); emit(BAD);
        emit(st(3, 5));            exp_wr(16'h0020, tgt);
        idle_addr = 16'hF000 + 16'(pc);
        emit(16'hA000); emit(idle_addr);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(posedge clk);
        check(tag, 16'(sb_q.size()), 16'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        hold  = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 16'hB000;
            ram[i] = 16'h0000;
        end
        build_program();
        repeat (2) @(posedge clk);
        #1;
        check("rst_address", address, 16'h0000);
        check("rst_write", {15'b0, write}, 16'd0);
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_data_out", data_out, 16'h0000);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        check("fetch0_addr", address, 16'hF000);
        check("fetch0_busy", {15'b0, busy}, 16'd1);
        check("fetch0_write", {15'b0, write}, 16'd0);
        repeat (3) @(posedge clk);
        #1 check("fetch1_addr", address, 16'hF001);

        wait_drain("run1_pending_writes");
        repeat (20) @(posedge clk);
        check("led_reg", led_reg, 16'h0100);
        check("ram_0010", ram[12'h010], 16'h0100);
        check("ram_0fff", ram[12'hFFF], 16'h0001);

        @(negedge clk) hold = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = !busy;
        end
        check("hold_reach_select", {15'b0, found}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_busy", {15'b0, busy}, 16'd0);
            check("hold_addr", address, idle_addr + 16'd1);
            check("hold_write", {15'b0, write}, 16'd0);
        end
        hold = 1'b0;
        @(posedge clk) #1;
        check("unhold_fetch", address, idle_addr);
        check("unhold_busy", {15'b0, busy}, 16'd1);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = busy && (address == idle_addr + 16'd1);
        end
        check("midload_found", {15'b0, found}, 16'd1);
        reset = 1'b1;
        build_program();
        @(posedge clk) #1;
        check("midrst_address", address, 16'h0000);
        check("midrst_write", {15'b0, write}, 16'd0);
        check("midrst_busy", {15'b0, busy}, 16'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        check("midrst_fetch", address, 16'hF000);
        wait_drain("run2_pending_writes");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/femto16_cpu.md
Name: femto16_cpu

Overview:
- 16-bit accumulator-style CPU core (femto16 ISA, 8 × 16-bit registers).
- Drives a single word-addressed bus that is shared by a synchronous ROM (program space 0xF000-0xFFFF), a synchronous RAM (0x0000-0x0FFF) and memory-mapped switch/LED registers.
- Address decode and the memories are external to this block.
- The bus assumes 1-cycle registered-read memories, and the core inserts wait states to match them.

Parameters:
- RESET_VECTOR, 16'hF000, value loaded into IP on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  stall request; honoured only at instruction boundary (state SELECT).
- busy  output  1  high whenever state != SELECT.
- address  output  16  registered bus address.
- data_in  input  16  read data from the external mux.
- data_out  output  16  registered write data.
- write  output  1  registered write strobe; memory commits on the rising edge that ends the cycle.

Behaviour:

Registers and flags:
- r0..r7, with r6 = SP and r7 = IP.
- Flags: C, Z, N.

Reset:
- Sampled on a clock edge while reset=1.
- r0-r6 = 0, IP = RESET_VECTOR, flags = 0.
- address = 0, data_out = 0, write = 0, state = SELECT.
- Overrides everything, including mid-instruction and hold.

Memory timing:
- data_in is sampled 2 edges after the edge that registered address.
- Every read therefore takes a WAIT state.

FSM states: SELECT, FETCH_WAIT, DECODE, MEM_WAIT, COMPUTE.
- SELECT:
  - write = 0.
  - If hold=1: stay in SELECT.
  - Otherwise: address = IP, IP = IP+1, go to FETCH_WAIT.
- FETCH_WAIT: go to DECODE.
- DECODE: latch data_in as the instruction and execute it per the encoding below.
- MEM_WAIT: go to COMPUTE.
- COMPUTE: ra = data_in, go to SELECT.

Encoding: op = [15:12], ra = [11:9], rb = [8:6], alu = [3:0], imm8 = [7:0].
- 0000 ALU: ra = ra alu rb; go to SELECT. Takes 3 cycles.
- 0001 LDI: ra = zero-extended imm8; update Z and N; go to SELECT.
- 0010 LD: address = rb; go to MEM_WAIT. Takes 5 cycles.
- 0011 ST: address = rb, data_out = ra, write = 1; go to SELECT. Memory writes during the SELECT cycle. Takes 3 cycles.
- 0100 LDW: address = IP, IP = IP+1; go to MEM_WAIT; ra = the following word.
- 0101 PUSH: SP = SP-1, address = SP-1, data_out = ra, write = 1; go to SELECT.
- 0110 POP: address = SP, SP = SP+1; go to MEM_WAIT.
- 1000 BR: if the condition in [11:8] holds, IP = IP + sign-extended imm8, where IP already points past the instruction.
  - Conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N.
  - Codes 7-15 never branch.
- 1001 JR: IP = ra.
- 1010 JMP: address = IP; go to MEM_WAIT; IP = the following word.
- All other opcodes: NOP, 3 cycles.

ALU op codes (alu field):
- 0 ZERO, 1 MOV (b), 2 ADD, 3 SUB, 4 ADC, 5 SBB, 6 AND, 7 OR.
- 8 XOR, 9 INC, 10 DEC, 11 ASL, 12 LSR, 13 ROL, 14 ROR, 15 NOT.

ALU flag and width rules:
- Every ALU op updates Z (result == 0) and N (result[15]).
- C is updated only by ADD, SUB, ADC, SBB, ASL, LSR, ROL and ROR; all other ops preserve it.
- ADD/ADC: C = carry out of bit 15.
- SUB/SBB: C = borrow, i.e. 1 when the unsigned result underflowed. SBB subtracts C.
- ASL and ROL shift bit 15 into C. LSR and ROR shift bit 0 into C.
- ROL and ROR rotate through C.
- Arithmetic is 16-bit and wraps: 0xFFFF+1 = 0x0000 with C=1.

Boundary behaviour:
- Writing r7 through ALU, LD or POP is a jump.
- SP wraps modulo 2^16.
- Loads do not affect flags.
- busy = 0 only in SELECT.

Test Plan:
- Reset: hold reset 2 cycles, release → first fetch address 0xF000, write=0, then address 0xF001 on the next fetch.
- ALU and flags:
  - LDI r0,0xFF; LDW r1,0x0001; ADD r0,r1 → r0=0x0100, C=0, Z=0.
  - LDW r2,0xFFFF; INC r2 → r2=0, Z=1, C unchanged.
  - SUB 1-2 → 0xFFFF, C=1, N=1.
- Memory:
  - ST r0→[0x0010], then LD r3,[0x0010] → write pulses 1 cycle with address=0x0010, data_out=0x0100; r3=0x0100.
  - Store to 0x2001 → write at address 0x2001 (LED register).
- Control flow:
  - Program at 0xF000: ZERO r0 ×3; JMP 0xF000 → address sequence loops F000..F004 forever; r0=0; Z=1.
  - BR !Z with disp -2 taken/not taken per Z.
- Stack: SP=0x1000; PUSH r1; POP r4 → write to 0x0FFF, r4=r1, SP back to 0x1000.
- Hold and reset:
  - Assert hold during an instruction → it completes, then the core stays in SELECT with busy=0 and no fetch until hold drops.
  - Assert reset mid-load → IP=0xF000 next cycle, write=0.
